// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings a PLL up and keeps it qualified. The sequence is: enable the PLL,
// wait for LOCK (bounded by a timeout), require LOCK to stay high for a run
// of consecutive cycles, then release the downstream reset. A timeout backs
// off (PLL disabled for a fixed time) and retries. Too many timeouts latch
// FAULT until software acknowledges it. Losing LOCK while running counts a
// loss, backs off and relocks.
//
// Parameters (legal range: all >= 1; the first three <= 65535)
//   LOCK_TIMEOUT   cycles allowed in WAIT_LOCK before a timeout
//   STABLE_CYCLES  consecutive synchronized-lock cycles needed before RUN
//   OFF_CYCLES     cycles pll_en is held low in BACKOFF
//   MAX_RETRIES    timeouts tolerated before FAULT
//
// Ports
//   clk_in       system clock (only clock)
//   reset_n      synchronous active-low reset
//   start        level request to run the PLL
//   lock_in      PLL LOCK, asynchronous to clk_in
//   clear_fault  single-cycle fault acknowledge (only honoured in FAULT)
//   pll_en       PLL enable
//   rst_out_n    active-low reset for the PLL-clocked domains
//   locked       PLL running and qualified
//   fault        retries exhausted
//   state        current FSM encoding
//   loss_count   saturating count of lock losses while running
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int LOCK_TIMEOUT  = 16,
  parameter int STABLE_CYCLES = 8,
  parameter int OFF_CYCLES    = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       start,
  input  logic       lock_in,
  input  logic       clear_fault,
  output logic       pll_en,
  output logic       rst_out_n,
  output logic       locked,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  // Counter widths; a parameter of 1 still needs a 1-bit counter.
  localparam int TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int OW = (OFF_CYCLES    > 1) ? $clog2(OFF_CYCLES)    : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [OW-1:0] OFF_LAST   = OW'(OFF_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    BACKOFF   = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;          // lock_in synchronizer, [1] is the output
  logic          lock_s;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] stab_q,  stab_d;
  logic [OW-1:0] off_q,   off_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] retry_inc;
  logic [7:0]    loss_q,  loss_d;

  assign lock_s    = sync_q[1];
  assign retry_inc = retry_q + 1'b1;

  // -------------------------------------------------------------------------
  // Registers: synchronizer, FSM state and all counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      timer_q <= '0;
      stab_q  <= '0;
      off_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], lock_in};
      state_q <= state_d;
      timer_q <= timer_d;
      stab_q  <= stab_d;
      off_q   <= off_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and counter updates.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    stab_d  = stab_q;
    off_d   = off_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    // Dropping start aborts everything except a latched fault, and wins
    // over any lock or timer event in the same cycle (no loss counted).
    if (state_q != FAULT && !start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        // start is known to be high on this path.
        IDLE: state_d = WAIT_LOCK;

        WAIT_LOCK: begin
          // Lock beats a coinciding timeout: no retry is charged.
          if (lock_s) begin
            state_d = STABLE;
          end else if (timer_q == TIMER_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? FAULT : BACKOFF;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        STABLE: begin
          // A dropout here is a glitch during qualification, not a loss.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (stab_q == STAB_LAST) begin
            state_d = RUN;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_d = BACKOFF;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end

        BACKOFF: begin
          if (off_q == OFF_LAST) state_d = WAIT_LOCK;
          else                   off_d   = off_q + 1'b1;
        end

        FAULT: begin
          if (clear_fault) begin
            state_d = IDLE;
            retry_d = '0;
          end
        end

        default: state_d = IDLE;   // unused encodings recover to IDLE
      endcase
    end

    // Each counter restarts from zero whenever its state is entered.
    // A successful qualification forgives earlier timeouts.
    if (state_d != state_q) begin
      case (state_d)
        WAIT_LOCK: timer_d = '0;
        STABLE:    stab_d  = '0;
        BACKOFF:   off_d   = '0;
        RUN:       retry_d = '0;
        default:   ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded straight from the state register.
  // -------------------------------------------------------------------------
  assign pll_en     = (state_q == WAIT_LOCK) || (state_q == STABLE) ||
                      (state_q == RUN);
  assign rst_out_n  = (state_q == RUN);
  assign locked     = (state_q == RUN);
  assign fault      = (state_q == FAULT);
  assign state      = state_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int LT = 16;
  localparam int SC = 8;
  localparam int OC = 4;
  localparam int MR = 3;

  logic       clk_in;
  logic       reset_n;
  logic       start;
  logic       lock_in;
  logic       clear_fault;
  logic       pll_en;
  logic       rst_out_n;
  logic       locked;
  logic       fault;
  logic [2:0] state;
  logic [7:0] loss_count;

  int errors = 0;
  int checks = 0;

  pll_lock_sequencer dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .start       (start),
    .lock_in     (lock_in),
    .clear_fault (clear_fault),
    .pll_en      (pll_en),
    .rst_out_n   (rst_out_n),
    .locked      (locked),
    .fault       (fault),
    .state       (state),
    .loss_count  (loss_count)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: one "phase" number, a single dwell counter (cycles
  // spent in the current phase), retry/loss tallies and a two-deep delay
  // line standing in for the synchronizer.
  // ---------------------------------------------------------------------
  int ms = 0, dwell = 0, retries = 0, losses = 0;
  bit s1 = 0, s2 = 0, mvalid = 0;

  function automatic void model_step(input bit rn, input bit st, input bit lk, input bit cf);
    int nxt;
    if (!rn) begin
      ms = 0; dwell = 0; retries = 0; losses = 0; s1 = 0; s2 = 0; mvalid = 1;
      return;
    end
    nxt = ms;
    if (ms != 5 && !st) nxt = 0;
    else if (ms == 0) nxt = 1;
    else if (ms == 1) begin
      if (s2) nxt = 2;
      else if (dwell == LT - 1) begin
        retries++;
        nxt = (retries == MR) ? 5 : 4;
      end
    end
    else if (ms == 2) begin
      if (!s2) nxt = 1;
      else if (dwell == SC - 1) nxt = 3;
    end
    else if (ms == 3) begin
      if (!s2) begin
        nxt = 4;
        if (losses < 255) losses++;
      end
    end
    else if (ms == 4) begin
      if (dwell == OC - 1) nxt = 1;
    end
    else if (ms == 5) begin
      if (cf) begin nxt = 0; retries = 0; end
    end
    if (nxt == 3 && ms != 3) retries = 0;
    dwell = (nxt != ms) ? 0 : dwell + 1;
    ms = nxt;
    s2 = s1;
    s1 = lk;
  endfunction

  always @(posedge clk_in) model_step(reset_n, start, lock_in, clear_fault);

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (mvalid) begin
      chk("m_state",      {29'd0, state}, ms);
      chk("m_pll_en",     pll_en,     (ms == 1 || ms == 2 || ms == 3));
      chk("m_rst_out_n",  rst_out_n,  (ms == 3));
      chk("m_locked",     locked,     (ms == 3));
      chk("m_fault",      fault,      (ms == 5));
      chk("m_loss_count", {24'd0, loss_count}, losses);
    end
  end

  task automatic wait_state(input logic [2:0] tgt, input int maxc, output int n);
    n = 0;
    while (state !== tgt && n < maxc) begin
      @(negedge clk_in);
      n++;
    end
    if (state !== tgt) chk($sformatf("wait_state_%0d", tgt), {29'd0, state}, {29'd0, tgt});
  endtask

  initial begin
    int n, lo, len;
    bit cur;
    int runs[$];
    int exp_runs[5];
    exp_runs[0] = 16; exp_runs[1] = 4; exp_runs[2] = 16; exp_runs[3] = 4; exp_runs[4] = 16;

    reset_n = 0; start = 0; lock_in = 0; clear_fault = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_state",     {29'd0, state}, 0);
    chk("rst_pll_en",    pll_en, 0);
    chk("rst_rst_out_n", rst_out_n, 0);
    chk("rst_locked",    locked, 0);
    chk("rst_fault",     fault, 0);
    chk("rst_loss",      {24'd0, loss_count}, 0);
    reset_n = 1;
    @(negedge clk_in);

    // Normal lock: lock_in rises 5 cycles after pll_en.
    start = 1;
    wait_state(1, 4, n);
    chk("pll_en_rise", pll_en, 1);
    repeat (4) @(negedge clk_in);
    lock_in = 1;
    wait_state(2, 20, n);
    chk("stable_after_pll_en", n + 4, 7);
    wait_state(3, 20, n);
    chk("run_after_stable", n, 8);
    chk("run_locked", locked, 1);
    chk("run_rst_out_n", rst_out_n, 1);

    // Loss in RUN.
    lock_in = 0;
    wait_state(4, 6, n);
    chk("loss_latency", n, 3);
    chk("loss_rst_out_n", rst_out_n, 0);
    chk("loss_locked", locked, 0);
    chk("loss_count_1", {24'd0, loss_count}, 1);
    lock_in = 1;
    lo = 0;
    while (pll_en === 1'b0 && lo < 20) begin
      @(negedge clk_in);
      lo++;
    end
    chk("backoff_len", lo, 4);
    wait_state(3, 30, n);

    // Start drop in RUN.
    start = 0;
    @(negedge clk_in);
    chk("drop_state", {29'd0, state}, 0);
    chk("drop_pll_en", pll_en, 0);
    chk("drop_loss", {24'd0, loss_count}, 1);
    repeat (2) @(negedge clk_in);

    // Glitch during STABLE.
    start = 1;
    wait_state(2, 10, n);
    repeat (2) @(negedge clk_in);
    lock_in = 0;
    @(negedge clk_in);
    lock_in = 1;
    wait_state(1, 5, n);
    chk("glitch_rst_out_n", rst_out_n, 0);
    chk("glitch_loss", {24'd0, loss_count}, 1);
    wait_state(2, 5, n);
    wait_state(3, 20, n);
    chk("restable_len", n, 8);

    // Start drop in the cycle the synchronized lock falls.
    lock_in = 0;
    repeat (2) @(negedge clk_in);
    start = 0;
    @(negedge clk_in);
    chk("prio_state", {29'd0, state}, 0);
    chk("prio_loss", {24'd0, loss_count}, 1);
    repeat (4) @(negedge clk_in);

    // Never lock: three timeouts then FAULT.
    start = 1;
    cur = 1; len = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (fault === 1'b1) break;
      if (pll_en === cur) len++;
      else begin
        runs.push_back(len);
        cur = pll_en;
        len = 1;
      end
    end
    runs.push_back(len);
    chk("nolock_runs", runs.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < runs.size()) chk($sformatf("nolock_run%0d", i), runs[i], exp_runs[i]);
    chk("fault_out", fault, 1);
    chk("fault_state", {29'd0, state}, 5);
    chk("fault_pll_en", pll_en, 0);
    start = 0;
    repeat (3) @(negedge clk_in);
    chk("fault_hold", {29'd0, state}, 5);
    clear_fault = 1;
    @(negedge clk_in);
    clear_fault = 0;
    chk("clear_to_idle", {29'd0, state}, 0);
    chk("clear_fault_out", fault, 0);

    // 300 forced losses saturate loss_count.
    start = 1; lock_in = 1;
    wait_state(3, 40, n);
    for (int k = 0; k < 300; k++) begin
      lock_in = 0;
      wait_state(4, 6, n);
      lock_in = 1;
      wait_state(3, 40, n);
      if (state !== 3'd3) break;
    end
    chk("loss_sat", {24'd0, loss_count}, 255);

    // Reset mid-RUN for one edge.
    reset_n = 0;
    @(negedge clk_in);
    chk("mid_rst_state",     {29'd0, state}, 0);
    chk("mid_rst_pll_en",    pll_en, 0);
    chk("mid_rst_rst_out_n", rst_out_n, 0);
    chk("mid_rst_locked",    locked, 0);
    chk("mid_rst_fault",     fault, 0);
    chk("mid_rst_loss",      {24'd0, loss_count}, 0);
    reset_n = 1;

    // Randomized phase, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      reset_n     = ($urandom_range(0, 399) != 0);
      start       = ($urandom_range(0, 99) < 97);
      clear_fault = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) lock_in = ~lock_in;
    end
    @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
